// File: rtl/alu_lab_pkg.sv
// Shared constants for the 8-bit lab ALU: widths, entry-stage
// encodings and opcodes. Imported by the loader, its bus and the ALU.
package alu_lab_pkg;

    localparam int DATA_W = 8;
    localparam int OP_W   = 3;

    localparam logic [1:0] S_LOAD_A  = 2'd0;
    localparam logic [1:0] S_LOAD_B  = 2'd1;
    localparam logic [1:0] S_LOAD_OP = 2'd2;
    localparam logic [1:0] S_RUN     = 2'd3;

    localparam logic [2:0] OP_NOT = 3'b000;
    localparam logic [2:0] OP_AND = 3'b001;
    localparam logic [2:0] OP_OR  = 3'b010;
    localparam logic [2:0] OP_XOR = 3'b100;

    typedef enum logic [1:0] {
        LOAD_A  = S_LOAD_A,
        LOAD_B  = S_LOAD_B,
        LOAD_OP = S_LOAD_OP,
        RUN     = S_RUN
    } stage_t;

endpackage

// File: rtl/alu_operand_loader_if.sv
// Operand bus from the loader to the ALU and LEDs.
// master: op_a, op_b, opcode, valid, stage driven; slave: all read.
interface alu_operand_if
    import alu_lab_pkg::*;
();

    logic [DATA_W-1:0] op_a;
    logic [DATA_W-1:0] op_b;
    logic [OP_W-1:0]   opcode;
    logic              valid;
    logic [1:0]        stage;

    modport master (
        output op_a, op_b, opcode, valid, stage
    );

    modport slave (
        input op_a, op_b, opcode, valid, stage
    );

endinterface

// File: rtl/alu_operand_loader_key_debounce.sv
// Pushbutton conditioning: 2-flop sync, stable-count debounce, press pulse.
// Ports: clk, rst_n (async low), key_n (raw, active-low), press (1 cycle).
module key_debounce #(
    parameter int DEBOUNCE_CYCLES = 1000000,
    parameter int CNT_W           = 20
) (
    input  logic clk,
    input  logic rst_n,
    input  logic key_n,
    output logic press
);

    logic             sync_1;
    logic             sync_2;
    logic             db;
    logic             db_d;
    logic [CNT_W-1:0] cnt;

    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

    // Reset to "released" so a key held through reset reads as a new press.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync_1 <= 1'b1;
            sync_2 <= 1'b1;
            db     <= 1'b1;
            db_d   <= 1'b1;
            cnt    <= '0;
        end else begin
            sync_1 <= key_n;
            sync_2 <= sync_1;
            db_d   <= db;
            if (sync_2 == db) begin
                cnt <= '0;
            end else if (cnt == CNT_LAST) begin
                db  <= sync_2;
                cnt <= '0;
            end else begin
                cnt <= cnt + 1'b1;
            end
        end
    end

    // Falling edge of the debounced key only; release is ignored.
    assign press = db_d & ~db;

endmodule

// File: rtl/alu_operand_loader.sv
// Operand entry stage: steps A -> B -> opcode -> run on each key press.
// Ports: clk, rst_n, sw_data, sw_op, key_n; alu bus (op_a/op_b/opcode/valid/stage).
module alu_operand_loader
    import alu_lab_pkg::*;
#(
    parameter int DEBOUNCE_CYCLES = 1000000,
    parameter int CNT_W           = 20
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [DATA_W-1:0] sw_data,
    input  logic [OP_W-1:0]   sw_op,
    input  logic              key_n,
    alu_operand_if.master     alu
);

    logic press;

    stage_t            state;
    stage_t            state_nx;
    logic [DATA_W-1:0] a_q;
    logic [DATA_W-1:0] a_nx;
    logic [DATA_W-1:0] b_q;
    logic [DATA_W-1:0] b_nx;
    logic [OP_W-1:0]   op_q;
    logic [OP_W-1:0]   op_nx;
    logic              valid_q;
    logic              valid_nx;

    key_debounce #(
        .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES),
        .CNT_W           (CNT_W)
    ) u_key (
        .clk   (clk),
        .rst_n (rst_n),
        .key_n (key_n),
        .press (press)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state   <= LOAD_A;
            a_q     <= '0;
            b_q     <= '0;
            op_q    <= '0;
            valid_q <= 1'b0;
        end else begin
            state   <= state_nx;
            a_q     <= a_nx;
            b_q     <= b_nx;
            op_q    <= op_nx;
            valid_q <= valid_nx;
        end
    end

    // Captured values persist across RUN -> LOAD_A until overwritten.
    always_comb begin
        state_nx = state;
        a_nx     = a_q;
        b_nx     = b_q;
        op_nx    = op_q;
        valid_nx = valid_q;
        if (press) begin
            unique case (state)
                LOAD_A: begin
                    a_nx     = sw_data;
                    state_nx = LOAD_B;
                end
                LOAD_B: begin
                    b_nx     = sw_data;
                    state_nx = LOAD_OP;
                end
                LOAD_OP: begin
                    op_nx    = sw_op;
                    valid_nx = 1'b1;
                    state_nx = RUN;
                end
                RUN: begin
                    valid_nx = 1'b0;
                    state_nx = LOAD_A;
                end
                default: state_nx = LOAD_A;
            endcase
        end
    end

    assign alu.op_a   = a_q;
    assign alu.op_b   = b_q;
    assign alu.opcode = op_q;
    assign alu.valid  = valid_q;
    assign alu.stage  = state;

endmodule

// File: tb/tb_alu_operand_loader.sv
// Bench for alu_operand_loader with DEBOUNCE_CYCLES=4, CNT_W=3.
// Vector table plus hand sequences for bounce, long hold and reset.
module tb_alu_operand_loader;
    import alu_lab_pkg::*;

    localparam int DC = 4;
    localparam int CW = 3;

    logic       clk = 1'b0;
    logic       rst_n = 1'b1;
    logic [7:0] sw_data = '0;
    logic [2:0] sw_op = '0;
    logic       key_n = 1'b1;

    alu_operand_if bus ();

    alu_operand_loader #(
        .DEBOUNCE_CYCLES (DC),
        .CNT_W           (CW)
    ) dut (
        .clk     (clk),
        .rst_n   (rst_n),
        .sw_data (sw_data),
        .sw_op   (sw_op),
        .key_n   (key_n),
        .alu     (bus.master)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [7:0] a;
        logic [7:0] b;
        logic [2:0] op;
        logic       v;
        logic [1:0] st;
    } out_t;

    typedef struct {
        logic [7:0] d;
        logic [2:0] o;
        int         hold;
        out_t       exp;
    } vec_t;

    out_t sbq[$];
    out_t cur;
    int   n_chk = 0;
    int   n_fail = 0;
    vec_t vecs[12];

    function automatic out_t snap();
        out_t r;
        r.a  = bus.op_a;
        r.b  = bus.op_b;
        r.op = bus.opcode;
        r.v  = bus.valid;
        r.st = bus.stage;
        return r;
    endfunction

    task automatic cmp(input string nm, input out_t exp);
        out_t act;
        act = snap();
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got a=%h b=%h op=%b v=%b st=%0d, want a=%h b=%h op=%b v=%b st=%0d",
                     nm, act.a, act.b, act.op, act.v, act.st,
                     exp.a, exp.b, exp.op, exp.v, exp.st);
        end
    endtask

    // Press for `hold` cycles; sw_data is d_early until edge 3, then d,
    // then d_late after the capture edge. Capture must land on edge DC+3.
    task automatic do_press(input string nm, input logic [7:0] d_early,
                            input logic [7:0] d, input logic [7:0] d_late,
                            input logic [2:0] o, input int hold,
                            input out_t exp);
        @(negedge clk);
        sw_data = d_early;
        sw_op   = o;
        key_n   = 1'b0;
        sbq.push_back(exp);
        for (int k = 1; k <= hold; k++) begin
            @(negedge clk);
            if (k == 3) sw_data = d;
            if (k == DC + 2) cmp({nm, ":pre"}, cur);
            if (k == DC + 3) begin
                n_chk++;
                if (sbq.size() == 0) begin
                    n_fail++;
                    $display("FAIL %s:sb got empty queue, want 1 entry", nm);
                end else begin
                    n_chk--;
                    cur = sbq.pop_front();
                    cmp({nm, ":cap"}, cur);
                end
            end
            if (k == DC + 4) sw_data = d_late;
        end
        cmp({nm, ":hold"}, cur);
        key_n = 1'b1;
        repeat (DC + 6) @(negedge clk);
        cmp({nm, ":rel"}, cur);
    endtask

    initial begin
        vecs[0]  = '{8'h56, 3'd0, 10, '{8'h56, 8'h00, 3'd0, 1'b0, 2'd1}};
        vecs[1]  = '{8'hB5, 3'd0, 10, '{8'h56, 8'hB5, 3'd0, 1'b0, 2'd2}};
        vecs[2]  = '{8'h00, 3'd1, 10, '{8'h56, 8'hB5, 3'd1, 1'b1, 2'd3}};
        vecs[3]  = '{8'hAA, 3'd7, 10, '{8'h56, 8'hB5, 3'd1, 1'b0, 2'd0}};
        vecs[4]  = '{8'h0F, 3'd0, 10, '{8'h0F, 8'hB5, 3'd1, 1'b0, 2'd1}};
        vecs[5]  = '{8'h33, 3'd7, 10, '{8'h0F, 8'h33, 3'd1, 1'b0, 2'd2}};
        vecs[6]  = '{8'hFF, 3'd6, 10, '{8'h0F, 8'h33, 3'd6, 1'b1, 2'd3}};
        vecs[7]  = '{8'h01, 3'd0, 10, '{8'h0F, 8'h33, 3'd6, 1'b0, 2'd0}};
        vecs[8]  = '{8'h11, 3'd2, 7,  '{8'h11, 8'h33, 3'd6, 1'b0, 2'd1}};
        vecs[9]  = '{8'h22, 3'd3, 7,  '{8'h11, 8'h22, 3'd6, 1'b0, 2'd2}};
        vecs[10] = '{8'h00, 3'd5, 7,  '{8'h11, 8'h22, 3'd5, 1'b1, 2'd3}};
        vecs[11] = '{8'h00, 3'd0, 7,  '{8'h11, 8'h22, 3'd5, 1'b0, 2'd0}};

        // Asynchronous reset between edges, then idle.
        cur = '0;
        #3 rst_n = 1'b0;
        #1 cmp("rst_async", cur);
        @(negedge clk);
        rst_n = 1'b1;
        repeat (10) @(negedge clk);
        cmp("idle10", cur);
        repeat (10) @(negedge clk);
        cmp("idle20", cur);

        for (int i = 0; i < 12; i++) begin
            if (i == 8) begin
                // Two short low bursts must not reach the debounce threshold.
                @(negedge clk);
                key_n = 1'b0;
                repeat (3) @(negedge clk);
                key_n = 1'b1;
                repeat (2) @(negedge clk);
                key_n = 1'b0;
                repeat (3) @(negedge clk);
                key_n = 1'b1;
                repeat (10) @(negedge clk);
                cmp("bounce", cur);
            end
            do_press($sformatf("vec%0d", i), vecs[i].d, vecs[i].d,
                     vecs[i].d, vecs[i].o, vecs[i].hold, vecs[i].exp);
        end

        // Long hold in LOAD_A; switches move before and after capture.
        do_press("hold200", 8'h44, 8'h99, 8'hEE, 3'd0, 200,
                 '{8'h99, 8'h22, 3'd5, 1'b0, 2'd1});

        // Reset mid-debounce in LOAD_B, key held low across release.
        @(negedge clk);
        key_n = 1'b0;
        repeat (3) @(negedge clk);
        #2 rst_n = 1'b0;
        cur = '0;
        sbq.delete();
        #1 cmp("rst_mid", cur);
        @(negedge clk);
        rst_n   = 1'b1;
        sw_data = 8'h5A;
        for (int k = 1; k <= 9; k++) begin
            @(negedge clk);
            if (k == DC + 2) cmp("rst_hold:pre", cur);
            if (k == DC + 3) begin
                cur = '{8'h5A, 8'h00, 3'd0, 1'b0, 2'd1};
                cmp("rst_hold:cap", cur);
            end
        end
        key_n = 1'b1;
        repeat (DC + 6) @(negedge clk);
        cmp("rst_hold:rel", cur);

        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_chk, n_fail);
        $finish;
    end

endmodule
